// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared load-type encodings, register constants and WB entry type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module : load_align
// Brief  : Little-endian byte/halfword extraction with sign/zero extension.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_align
    import mips_pkg::*;
(
    input  logic [31:0] i_mem_data,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_load_type,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_mem_data[7:0];
            2'd1:    w_byte = i_mem_data[15:8];
            2'd2:    w_byte = i_mem_data[23:16];
            default: w_byte = i_mem_data[31:24];
        endcase
        // Halfword alignment uses only offset[1]; offset[0] is ignored.
        w_half = i_offset[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    end

    always_comb begin
        o_data = i_mem_data;
        case (i_load_type)
            LT_LH:   o_data = {{16{w_half[15]}}, w_half};
            LT_LHU:  o_data = {16'h0000, w_half};
            LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  o_data = {24'h000000, w_byte};
            default: o_data = i_mem_data;
        endcase
    end

endmodule : load_align

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module : wb_stage
// Brief  : Write-back pipeline register with load alignment, hold/flush and
//          retirement counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        hold,
    input  logic        flush,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_mem_data,
    input  logic [2:0]  in_load_type,
    output logic        write,
    output logic [4:0]  writereg,
    output logic [31:0] writedata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data,
    output logic [31:0] retire_count
);

    wb_entry_t   entry_q, entry_d;
    logic        written_q, written_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic [31:0] w_load_data;

    load_align u_load_align (
        .i_mem_data  (in_mem_data),
        .i_offset    (in_alu_result[1:0]),
        .i_load_type (in_load_type),
        .o_data      (w_load_data)
    );

    assign in_ready = !hold;

    always_comb begin
        entry_d        = entry_q;
        written_d      = written_q;
        retire_count_d = retire_count_q;

        // A valid entry retires whenever the stage advances, even under flush.
        if (entry_q.valid && !hold) begin
            retire_count_d = retire_count_q + 32'd1;
        end

        if (flush) begin
            entry_d.valid = 1'b0;
            written_d     = 1'b0;
        end else if (hold) begin
            // Entry already reached the register file once; block repeats.
            written_d = entry_q.valid;
        end else begin
            entry_d.valid = in_valid;
            written_d     = 1'b0;
            if (in_valid) begin
                entry_d.regwrite = in_regwrite;
                entry_d.rd       = in_rd;
                entry_d.data     = in_memtoreg ? w_load_data : in_alu_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q        <= '0;
            written_q      <= 1'b0;
            retire_count_q <= 32'd0;
        end else begin
            entry_q        <= entry_d;
            written_q      <= written_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign write        = entry_q.valid && entry_q.regwrite &&
                          (entry_q.rd != REG_ZERO) && !written_q;
    assign writereg     = entry_q.rd;
    assign writedata    = entry_q.data;
    assign fwd_valid    = write;
    assign fwd_reg      = writereg;
    assign fwd_data     = writedata;
    assign retire_count = retire_count_q;

endmodule : wb_stage

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module : tb_wb_stage
// Brief  : Scoreboard bench for wb_stage with directed load/hold/flush vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        hold;
    logic        flush;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [2:0]  in_load_type;
    logic        write;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic [31:0] retire_count;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .hold          (hold),
        .flush         (flush),
        .in_regwrite   (in_regwrite),
        .in_memtoreg   (in_memtoreg),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .in_load_type  (in_load_type),
        .write         (write),
        .writereg      (writereg),
        .writedata     (writedata),
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Drive one cycle of stimulus; returns at the next falling edge.
    task automatic step(input logic v, input logic h, input logic f, input logic r,
                        input logic rw, input logic m2r, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [2:0] lt);
        in_valid      = v;
        hold          = h;
        flush         = f;
        rst           = r;
        in_regwrite   = rw;
        in_memtoreg   = m2r;
        in_rd         = rd;
        in_alu_result = alu;
        in_mem_data   = mem;
        in_load_type  = lt;
        @(negedge clk);
    endtask

    // Issue an instruction whose register-file write is expected next cycle.
    task automatic issue(input logic m2r, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [2:0] lt,
                         input logic [31:0] expdata);
        exp_t e;
        e.rd   = rd;
        e.data = expdata;
        exp_q.push_back(e);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, m2r, rd, alu, mem, lt);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0);
    endtask

    // Monitor: every register-file write must match the next expected entry.
    always @(negedge clk) begin
        if (write === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d data 0x%08h expected no write",
                         writereg, writedata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("writereg", {27'd0, writereg}, {27'd0, e.rd});
                check("writedata", writedata, e.data);
                check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
                check("fwd_reg", {27'd0, fwd_reg}, {27'd0, e.rd});
                check("fwd_data", fwd_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
        in_regwrite = 1'b0; in_memtoreg = 1'b0; in_rd = 5'd0;
        in_alu_result = 32'd0; in_mem_data = 32'd0; in_load_type = 3'd0;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0);
        check("reset_write", {31'd0, write}, 32'd0);
        check("reset_writereg", {27'd0, writereg}, 32'd0);
        check("reset_writedata", writedata, 32'd0);
        check("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("reset_retire", retire_count, 32'd0);

        // Back-to-back load/ALU mix
        issue(1'b1, 5'd5,  32'h0000_1001, 32'h1234_80FF, 3'd3, 32'hFFFF_FF80); // LB off1
        issue(1'b1, 5'd7,  32'h0000_2002, 32'h8001_1234, 3'd2, 32'h0000_8001); // LHU off2
        issue(1'b1, 5'd7,  32'h0000_2002, 32'h8001_1234, 3'd1, 32'hFFFF_8001); // LH off2
        issue(1'b1, 5'd9,  32'h0000_0100, 32'hCAFE_F00D, 3'd0, 32'hCAFE_F00D); // LW
        issue(1'b1, 5'd10, 32'h0000_0003, 32'h9A00_0000, 3'd4, 32'h0000_009A); // LBU off3
        issue(1'b1, 5'd11, 32'h0000_0002, 32'h0045_0000, 3'd3, 32'h0000_0045); // LB off2
        issue(1'b0, 5'd12, 32'h1234_5678, 32'hFFFF_FFFF, 3'd3, 32'h1234_5678); // ALU
        issue(1'b1, 5'd13, 32'h0000_0001, 32'h0000_F00F, 3'd1, 32'hFFFF_F00F); // LH off1
        issue(1'b1, 5'd14, 32'h0000_0002, 32'h0102_0304, 3'd7, 32'h0102_0304); // bad code
        bubble();
        check("retire_after_batch", retire_count, 32'd9);

        // Write to $zero is suppressed but still retires
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'd0, 3'd0);
        check("zero_reg_write", {31'd0, write}, 32'd0);
        bubble();
        check("retire_zero_reg", retire_count, 32'd10);

        // Hold for three cycles: one write, count frozen until release
        issue(1'b0, 5'd3, 32'h0000_0033, 32'd0, 3'd0, 32'h0000_0033);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0000_0044, 32'd0, 3'd0);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_write", {31'd0, write}, 32'd0);
            check("hold_writereg", {27'd0, writereg}, 32'd3);
            check("hold_retire", retire_count, 32'd10);
        end
        bubble();
        check("hold_release_retire", retire_count, 32'd11);
        check("release_ready", {31'd0, in_ready}, 32'd1);

        // Flush with in_valid: incoming dropped, previous entry counted
        issue(1'b0, 5'd20, 32'h0000_0020, 32'd0, 3'd0, 32'h0000_0020);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd21, 32'h0000_0021, 32'd0, 3'd0);
        check("flush_write", {31'd0, write}, 32'd0);
        check("flush_retire", retire_count, 32'd12);
        bubble();
        check("flush_bubble_retire", retire_count, 32'd12);

        // Counter wrap
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        issue(1'b0, 5'd22, 32'h0000_0022, 32'd0, 3'd0, 32'h0000_0022);
        check("preload_retire", retire_count, 32'hFFFF_FFFF);
        bubble();
        check("wrap_retire", retire_count, 32'd0);

        // Reset mid-stream discards the in-flight entry
        issue(1'b0, 5'd25, 32'h0000_0025, 32'd0, 3'd0, 32'h0000_0025);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd26, 32'h0000_0026, 32'd0, 3'd0);
        check("midrst_write", {31'd0, write}, 32'd0);
        check("midrst_writereg", {27'd0, writereg}, 32'd0);
        check("midrst_writedata", writedata, 32'd0);
        check("midrst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("midrst_retire", retire_count, 32'd0);
        bubble();
        bubble();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule : tb_wb_stage

`default_nettype wire
